// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
//   Measurement front end of the reaction-time game. A start request arms a
//   pseudo-random wait. After the wait the GO LED lights, and the block counts
//   whole milliseconds until the player presses the button. The result is a
//   13-bit millisecond count that saturates at 8191 (a timeout). A press during
//   the random wait is reported as a false start.
//
// Ports
//   clk           in   1   system clock, rising-edge
//   reset         in   1   synchronous, active-high, clears all state
//   start         in   1   one-cycle request to begin a round (ignored while busy)
//   button        in   1   debounced player button, asynchronous to clk
//   busy          out  1   round in progress (WAIT_DELAY or GO)
//   go_led        out  1   GO LED, lit only in GO
//   result_ms     out  13  measured reaction time, held until overwritten
//   result_valid  out  1   result_ms holds a fresh measurement (DONE)
//   false_start   out  1   button pressed before GO (FALSE_START)
//   timeout       out  1   DONE reached because the count saturated
//   dbg_state     out  3   current FSM state encoding, for observation only
//
// Handshake: start is a plain one-cycle request. It is accepted only in IDLE,
// DONE or FALSE_START and produces no acknowledge. The round outcome is shown
// by the level outputs. They are valid from the cycle after the edge that
// makes the transition.
// -----------------------------------------------------------------------------
module reaction_timer #(
    parameter int TICKS_PER_MS = 50000,
    parameter int DELAY_MIN_MS = 1000,
    parameter int DELAY_BITS   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        button,
    output logic        busy,
    output logic        go_led,
    output logic [12:0] result_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic [2:0]  dbg_state
);

    localparam int            PW         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [12:0]   MS_MAX     = 13'd8191;
    localparam logic [12:0]   DELAY_MIN  = 13'(DELAY_MIN_MS);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_DELAY  = 3'd1,
        S_GO          = 3'd2,
        S_DONE        = 3'd3,
        S_FALSE_START = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_btn_d;
    logic [15:0]   r_lfsr;
    logic [PW-1:0] r_presc;
    logic [12:0]   r_delay_cnt;
    logic [12:0]   r_ms_cnt;
    logic [12:0]   r_result;
    logic          r_timeout;

    logic          w_press;
    logic          w_lfsr_fb;
    logic          w_ms_tick;
    logic [12:0]   w_delay_load;

    // Press is the rising edge seen after the two-flop synchronizer. A pin
    // rise therefore takes effect on the third clock edge after it.
    assign w_press      = r_sync2 & ~r_btn_d;
    // Fibonacci taps 16,14,13,11. These taps give the full 65535-state
    // sequence, so a non-zero seed never reaches zero.
    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_ms_tick    = (r_presc == PRESC_LAST);
    assign w_delay_load = DELAY_MIN + 13'(r_lfsr[DELAY_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_btn_d <= 1'b0;
            r_lfsr  <= 16'hACE1;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            r_btn_d <= r_sync2;
            r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_delay_cnt <= '0;
            r_ms_cnt    <= '0;
            r_result    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            // The prescaler free-runs. Every entry into WAIT_DELAY or GO
            // overrides it to zero, so the first millisecond after entry is
            // always a full one.
            r_presc <= w_ms_tick ? '0 : r_presc + 1'b1;
            case (r_state)
                S_IDLE, S_DONE, S_FALSE_START: begin
                    if (start) begin
                        r_state     <= S_WAIT_DELAY;
                        r_delay_cnt <= w_delay_load;
                        r_presc     <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_WAIT_DELAY: begin
                    if (w_press) begin
                        r_state <= S_FALSE_START;
                    end else if (w_ms_tick) begin
                        // Testing for <= 1 also covers a zero load.
                        // Without it, a zero load would count down
                        // through 8191.
                        if (r_delay_cnt <= 13'd1) begin
                            r_state  <= S_GO;
                            r_ms_cnt <= '0;
                            r_presc  <= '0;
                        end else begin
                            r_delay_cnt <= r_delay_cnt - 13'd1;
                        end
                    end
                end
                S_GO: begin
                    // A press in the same cycle as a tick captures the count
                    // from before that tick.
                    if (w_press) begin
                        r_state  <= S_DONE;
                        r_result <= r_ms_cnt;
                    end else if (w_ms_tick) begin
                        if (r_ms_cnt == MS_MAX) begin
                            r_state   <= S_DONE;
                            r_result  <= MS_MAX;
                            r_timeout <= 1'b1;
                        end else begin
                            r_ms_cnt <= r_ms_cnt + 13'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (r_state == S_WAIT_DELAY) || (r_state == S_GO);
    assign go_led       = (r_state == S_GO);
    assign result_valid = (r_state == S_DONE);
    assign false_start  = (r_state == S_FALSE_START);
    assign timeout      = r_timeout;
    assign result_ms    = r_result;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_reaction_timer.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer
//   Bench for reaction_timer, built with TICKS_PER_MS=4, DELAY_MIN_MS=2 and
//   DELAY_BITS=3. For each round the driver works out the outcome on a
//   timeline:
//     start sampled at edge E0, delay D  -> GO entered at edge G = E0 + D*T
//     button raised after edge e         -> press acted on at edge P = e + 3
//     P <= G                             -> false start at P, result unchanged
//     G < P <= G + 8192*T                -> done at P, result = (P-G-1)/T
//     no press                           -> timeout at G + 8192*T, result 8191
//   The expected events go into queues. The monitor pops an entry when go_led
//   rises or when an outcome appears, and compares against it.
// -----------------------------------------------------------------------------
module tb_reaction_timer;

  localparam int T    = 4;
  localparam int MIN  = 2;
  localparam int DB   = 3;
  localparam int MASK = (1 << DB) - 1;
  localparam int SAT  = 8191;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        button;
  logic        busy;
  logic        go_led;
  logic [12:0] result_ms;
  logic        result_valid;
  logic        false_start;
  logic        timeout;
  logic [2:0]  dbg_state;

  reaction_timer #(.TICKS_PER_MS(T), .DELAY_MIN_MS(MIN), .DELAY_BITS(DB)) dut (
    .clk(clk), .reset(reset), .start(start), .button(button),
    .busy(busy), .go_led(go_led), .result_ms(result_ms),
    .result_valid(result_valid), .false_start(false_start),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / edge count / LFSR reference ----------------
  always #5 clk = ~clk;

  int          cyc = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= reset ? 16'hACE1
                    : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=90000", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        fs;
    logic        to;
    logic [12:0] res;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   go_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   last_res = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_go  = 1'b0;
  logic prev_out = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (go_led && !prev_go) begin
        if (go_q.size() == 0) begin
          check("go_unexpected", 1, 0);
        end else begin
          check("go_edge", cyc, go_q.pop_front());
          check("go_busy", busy, 1);
        end
      end
      if ((result_valid || false_start) && !prev_out) begin
        if (exp_q.size() == 0) begin
          check("outcome_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("false_start", false_start, e.fs);
          check("result_valid", result_valid, !e.fs);
          check("result_ms", result_ms, e.res);
          check("timeout", timeout, e.to);
          check("outcome_edge", cyc, e.cyc);
          check("busy_after", busy, 0);
          check("go_after", go_led, 0);
        end
      end
    end
    prev_go  <= go_led;
    prev_out <= result_valid || false_start;
  end

  // ---------------- driver tasks ----------------
  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_go"}, go_led, 0);
    check({tag, "_result"}, result_ms, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_fs"}, false_start, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // Issue start at the next edge. Returns E0 and the expected G.
  task automatic issue_start(input bit force_zero, output int e0, output int g);
    int n;
    n = 0;
    while (force_zero && ((m_lfsr & MASK) != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (force_zero) check("lfsr_zero_found", (m_lfsr & MASK), 0);
    e0 = cyc + 1;
    g  = e0 + (MIN + (m_lfsr & MASK)) * T;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_round(input bit force_zero, input bit do_press, input int press_off,
                           input bit busy_starts, input bit hold_btn);
    int   e0, g, p, outcome;
    exp_t e;
    if (hold_btn) begin
      // This rise lands while the FSM is idle, so it must be ignored.
      button = 1'b1;
      repeat (6) @(negedge clk);
    end
    issue_start(force_zero, e0, g);
    p = 0;
    if (do_press) begin
      p = g + press_off;
      if (p < e0 + 3) p = e0 + 3;
    end
    if (do_press && p <= g) begin
      e = '{fs: 1'b1, to: 1'b0, res: 13'(last_res), cyc: 32'(p)};
      outcome = p;
    end else if (do_press) begin
      go_q.push_back(g);
      last_res = (p - g - 1) / T;
      e = '{fs: 1'b0, to: 1'b0, res: 13'(last_res), cyc: 32'(p)};
      outcome = p;
    end else begin
      go_q.push_back(g);
      outcome = g + 8192 * T;
      last_res = SAT;
      e = '{fs: 1'b0, to: 1'b1, res: 13'(SAT), cyc: 32'(outcome)};
    end
    exp_q.push_back(e);
    while (cyc < outcome + 2) begin
      start = 1'b0;
      if (busy_starts && (cyc == e0 + 1 || cyc == g + 1) && (cyc + 1 < outcome)) start = 1'b1;
      if (hold_btn && cyc == g + 1) button = 1'b0;
      if (do_press && cyc == p - 3) button = 1'b1;
      @(negedge clk);
    end
    start  = 1'b0;
    button = 1'b0;
    repeat (5) @(negedge clk);
    check("outcome_seen", exp_q.size(), 0);
    check("go_seen", go_q.size(), 0);
    exp_q.delete();
    go_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0, g, off;
    bit hold;
    reset  = 1'b1;
    start  = 1'b0;
    button = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cleared("reset");

    // Zero random part (D = MIN): press 5 ms after GO.
    run_round(1'b1, 1'b1, 5 * T + 1, 1'b0, 1'b0);
    // Press acted on the same edge as the tick that would make ms_cnt 8.
    run_round(1'b0, 1'b1, 8 * T, 1'b0, 1'b0);
    // Press during the wait, and press on the GO-entry edge itself.
    run_round(1'b0, 1'b1, -5, 1'b0, 1'b0);
    run_round(1'b1, 1'b1, 0, 1'b0, 1'b0);
    // Button held across GO entry, extra starts while busy.
    run_round(1'b0, 1'b1, 3 * T + 2, 1'b1, 1'b1);

    // Reset in the middle of GO.
    issue_start(1'b0, e0, g);
    go_q.push_back(g);
    while (cyc < g + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_cleared("mid_go_reset");
    check("go_before_reset", go_q.size(), 0);
    go_q.delete();
    last_res = 0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      off  = int'($urandom_range(0, 18 * T)) - 8 * T;
      hold = 1'($urandom_range(0, 3) == 0);
      if (hold && off < 10) off = 10;
      run_round(1'($urandom_range(0, 1)), 1'b1, off, 1'($urandom_range(0, 1)), hold);
    end

    // Saturation, then a false start that must keep 8191 and clear timeout.
    run_round(1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_round(1'b0, 1'b1, -3, 1'b0, 1'b0);
    run_round(1'b0, 1'b1, 2 * T + 3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
